// File: rtl/fb_pingpong_ctrl.sv
// Ping-pong frame buffer scheduler: steers capture writes into the back bank
// and swaps front/back only on a reader frame boundary after a complete back frame.
module fb_pingpong_ctrl #(
    parameter int C_NB_ADDR  = 13,
    parameter int C_IMG_PXLS = 4800
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cap_we,
    input  logic [C_NB_ADDR-1:0] cap_addr,
    input  logic                 freeze,
    input  logic                 rd_frame_done,
    output logic                 wea_bank0,
    output logic                 wea_bank1,
    output logic                 rd_sel,
    output logic                 swap_pulse,
    output logic [1:0]           state_o,
    output logic [7:0]           drop_cnt
);

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_READY  = 2'd2,
        ST_FROZEN = 2'd3
    } state_t;

    localparam logic [C_NB_ADDR-1:0] LAST_ADDR  = C_NB_ADDR'(C_IMG_PXLS - 1);
    localparam logic [C_NB_ADDR-1:0] FIRST_ADDR = {C_NB_ADDR{1'b0}};

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            sat_inc8 = v;
        end else begin
            sat_inc8 = v + 8'd1;
        end
    endfunction

    state_t     state_q, state_d;
    logic       rd_sel_q, rd_sel_d;
    logic       swap_q, swap_d;
    logic [7:0] drop_q, drop_d;
    logic       back_we_s;
    logic       is_start_s;
    logic       is_last_s;
    logic       in_frame_s;

    assign is_start_s = cap_we && (cap_addr == FIRST_ADDR);
    assign is_last_s  = cap_we && (cap_addr == LAST_ADDR);
    assign in_frame_s = cap_we && (cap_addr <= LAST_ADDR);

    // State register, front-bank select, swap strobe and drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_SYNC;
            rd_sel_q <= 1'b0;
            swap_q   <= 1'b0;
            drop_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            rd_sel_q <= rd_sel_d;
            swap_q   <= swap_d;
            drop_q   <= drop_d;
        end
    end

    // Next-state logic and back-bank write gating
    always_comb begin
        state_d   = state_q;
        rd_sel_d  = rd_sel_q;
        swap_d    = 1'b0;
        drop_d    = drop_q;
        back_we_s = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (freeze) begin
                    state_d = ST_FROZEN;
                end else if (is_start_s) begin
                    back_we_s = 1'b1;
                    state_d   = ST_WRITE;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_WRITE: begin
                // freeze wins over the last pixel so a half-written frame is never promoted
                if (freeze) begin
                    state_d = ST_FROZEN;
                end else if (in_frame_s) begin
                    back_we_s = 1'b1;
                    if (is_last_s) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READY: begin
                if (is_start_s) begin
                    drop_d = sat_inc8(drop_q);
                end else begin
                    drop_d = drop_q;
                end
                if (freeze) begin
                    state_d = ST_FROZEN;
                end else if (rd_frame_done) begin
                    rd_sel_d = ~rd_sel_q;
                    swap_d   = 1'b1;
                    state_d  = ST_SYNC;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_FROZEN: begin
                if (!freeze) begin
                    state_d = ST_SYNC;
                end else begin
                    state_d = ST_FROZEN;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // Back bank is the one the reader is not using
    assign wea_bank0  = back_we_s & rd_sel_q;
    assign wea_bank1  = back_we_s & ~rd_sel_q;
    assign rd_sel     = rd_sel_q;
    assign swap_pulse = swap_q;
    assign state_o    = state_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_fb_pingpong_ctrl.sv
// Directed self-checking bench for fb_pingpong_ctrl.
module tb_fb_pingpong_ctrl;

    localparam int NB = 13;
    localparam int PX = 4800;

    logic          clk;
    logic          rst;
    logic          cap_we;
    logic [NB-1:0] cap_addr;
    logic          freeze;
    logic          rd_frame_done;
    logic          wea_bank0;
    logic          wea_bank1;
    logic          rd_sel;
    logic          swap_pulse;
    logic [1:0]    state_o;
    logic [7:0]    drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int errs   = 0;

    fb_pingpong_ctrl #(.C_NB_ADDR(NB), .C_IMG_PXLS(PX)) dut (
        .clk           (clk),
        .rst           (rst),
        .cap_we        (cap_we),
        .cap_addr      (cap_addr),
        .freeze        (freeze),
        .rd_frame_done (rd_frame_done),
        .wea_bank0     (wea_bank0),
        .wea_bank1     (wea_bank1),
        .rd_sel        (rd_sel),
        .swap_pulse    (swap_pulse),
        .state_o       (state_o),
        .drop_cnt      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input int addr, input logic frz, input logic done);
        @(negedge clk);
        cap_we        = we;
        cap_addr      = addr[NB-1:0];
        freeze        = frz;
        rd_frame_done = done;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes lo..hi and counts cycles where the expected back bank was not the sole enabled one
    task automatic write_range(input int lo, input int hi, input logic bank, output int e);
        e = 0;
        for (int a = lo; a <= hi; a++) begin
            drive(1'b1, a, 1'b0, 1'b0);
            if (bank == 1'b0) begin
                if (wea_bank0 !== 1'b1 || wea_bank1 !== 1'b0) e++;
            end else begin
                if (wea_bank1 !== 1'b1 || wea_bank0 !== 1'b0) e++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; cap_we = 1'b0; cap_addr = '0; freeze = 1'b0; rd_frame_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_state", state_o, 0);
        chk_eq("rst_rd_sel", rd_sel, 0);
        chk_eq("rst_swap", swap_pulse, 0);
        chk_eq("rst_drop", drop_cnt, 0);
        chk_eq("rst_wea0", wea_bank0, 0);
        chk_eq("rst_wea1", wea_bank1, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: first frame into bank1
        drive(1'b1, 5, 1'b0, 1'b0);
        chk_eq("sync_mask_wea1", wea_bank1, 0);
        tick();
        chk_eq("sync_hold_state", state_o, 0);
        write_range(0, 0, 1'b1, errs);
        chk_eq("start_wea1", errs, 0);
        tick();
        chk_eq("start_state", state_o, 1);
        write_range(1, PX - 2, 1'b1, errs);
        chk_eq("frame1_mirror_errs", errs, 0);
        drive(1'b1, PX - 1, 1'b0, 1'b0);
        chk_eq("last_wea1", wea_bank1, 1);
        chk_eq("last_wea0", wea_bank0, 0);
        tick();
        chk_eq("ready_state", state_o, 2);
        chk_eq("ready_rd_sel", rd_sel, 0);

        // 2: swap on reader frame boundary, then fill bank0
        drive(1'b0, 0, 1'b0, 1'b1);
        tick();
        chk_eq("swap_rd_sel", rd_sel, 1);
        chk_eq("swap_pulse", swap_pulse, 1);
        chk_eq("swap_state", state_o, 0);
        drive(1'b0, 0, 1'b0, 1'b0);
        tick();
        chk_eq("swap_pulse_1cyc", swap_pulse, 0);
        write_range(0, PX - 1, 1'b0, errs);
        chk_eq("frame2_bank0_errs", errs, 0);
        tick();
        chk_eq("frame2_ready", state_o, 2);

        // 3: drops while READY, saturating
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 0, 1'b0, 1'b0);
            if (wea_bank0 !== 1'b0 || wea_bank1 !== 1'b0) errs++;
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        chk_eq("drop_wea_errs", errs, 0);
        chk_eq("drop_cnt_3", drop_cnt, 3);
        for (int i = 0; i < 297; i++) begin
            drive(1'b1, 0, 1'b0, 1'b0);
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        chk_eq("drop_cnt_sat", drop_cnt, 255);
        chk_eq("drop_state", state_o, 2);
        chk_eq("drop_rd_sel", rd_sel, 1);

        // 5: last pixel and rd_frame_done together -> READY only
        drive(1'b0, 0, 1'b0, 1'b1);
        tick();
        chk_eq("t5_swap_rd_sel", rd_sel, 0);
        write_range(0, PX - 2, 1'b1, errs);
        chk_eq("t5_frame_errs", errs, 0);
        drive(1'b1, PX - 1, 1'b0, 1'b1);
        chk_eq("t5_last_wea1", wea_bank1, 1);
        tick();
        chk_eq("t5_state", state_o, 2);
        chk_eq("t5_no_swap_sel", rd_sel, 0);
        chk_eq("t5_no_swap_pulse", swap_pulse, 0);
        drive(1'b0, 0, 1'b0, 1'b1);
        tick();
        chk_eq("t5_late_swap_sel", rd_sel, 1);
        chk_eq("t5_late_swap_pulse", swap_pulse, 1);

        // 4: freeze mid-frame
        write_range(0, 1999, 1'b0, errs);
        chk_eq("t4_frame_errs", errs, 0);
        drive(1'b1, 2000, 1'b1, 1'b0);
        chk_eq("t4_frz_wea0", wea_bank0, 0);
        chk_eq("t4_frz_wea1", wea_bank1, 0);
        tick();
        chk_eq("t4_frozen", state_o, 3);
        chk_eq("t4_rd_sel", rd_sel, 1);
        drive(1'b1, 0, 1'b1, 1'b1);
        chk_eq("t4_frozen_wea0", wea_bank0, 0);
        tick();
        chk_eq("t4_frozen_hold", state_o, 3);
        chk_eq("t4_frozen_sel", rd_sel, 1);
        chk_eq("t4_frozen_noswap", swap_pulse, 0);
        drive(1'b0, 0, 1'b0, 1'b0);
        tick();
        chk_eq("t4_release", state_o, 0);
        drive(1'b1, 7, 1'b0, 1'b0);
        chk_eq("t4_sync_mask", wea_bank0, 0);
        write_range(0, 0, 1'b0, errs);
        chk_eq("t4_restart_wea0", errs, 0);
        tick();
        chk_eq("t4_resume", state_o, 1);
        drive(1'b1, 5000, 1'b0, 1'b0);
        chk_eq("oob_wea0", wea_bank0, 0);
        tick();
        chk_eq("oob_state", state_o, 1);

        // 6: async reset mid-frame with rd_sel=1
        write_range(1, 999, 1'b0, errs);
        chk_eq("t6_frame_errs", errs, 0);
        @(negedge clk);
        cap_we = 1'b1; cap_addr = 13'd1000; rst = 1'b1;
        #1;
        chk_eq("t6_rd_sel", rd_sel, 0);
        chk_eq("t6_state", state_o, 0);
        chk_eq("t6_drop", drop_cnt, 0);
        chk_eq("t6_wea0", wea_bank0, 0);
        chk_eq("t6_wea1", wea_bank1, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1002, 1'b0, 1'b0);
        chk_eq("t6_post_wea1", wea_bank1, 0);
        write_range(0, PX - 1, 1'b1, errs);
        chk_eq("t6_frame_errs2", errs, 0);
        tick();
        chk_eq("t6_ready", state_o, 2);

        // drop and swap in the same cycle
        drive(1'b1, 0, 1'b0, 1'b1);
        chk_eq("dual_wea1", wea_bank1, 0);
        tick();
        chk_eq("dual_drop", drop_cnt, 1);
        chk_eq("dual_rd_sel", rd_sel, 1);
        chk_eq("dual_swap", swap_pulse, 1);
        chk_eq("dual_state", state_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
